inert_spi_serf: RTL and testbench

Synthesizable, parametrised successor to the inertial-sensor SPI serf model. It runs entirely on the system clock, with SCLK, SS_n and MOSI oversampled. Key features:
- Burst reads and writes with address auto-increment.
- Selectable output data rate (ODR).
- Coherent sample snapshots of NUM_CH 16-bit sensor channels.
- An INT flag.

It sits between the SPI monarch and the sensor data source, as the drop-in sensor front end for simulation and FPGA test benches.

---
 rtl/inert_spi_serf_if.sv | 8 +
 rtl/inert_spi_serf.sv | 147 ++++++++++++++
 tb/tb_inert_spi_serf.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/inert_spi_serf_if.sv
// inert_spi_serf_if: monarch-driven SPI pins shared by the monarch model and the sensor serf
interface inert_spi_serf_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  modport master (output SS_n, output SCLK, output MOSI);
  modport slave (input SS_n, input SCLK, input MOSI);
endinterface

// File: rtl/inert_spi_serf.sv
// inert_spi_serf: oversampled mode-0 SPI serf for an inertial sensor with ODR-paced coherent snapshots
module inert_spi_serf #(
  parameter int NUM_CH = 6,
  parameter logic [6:0] DATA_BASE = 7'h22,
  parameter logic [7:0] WHO_AM_I = 8'h6A,
  parameter int ODR_BASE = 4096
) (
  input  logic clk,
  input  logic rst,
  inert_spi_serf_if.slave spi,
  output logic MISO,
  output logic INT,
  input  logic [16*NUM_CH-1:0] sens_data,
  output logic setup
);
  localparam int CW = $clog2(8*ODR_BASE) + 1;
  localparam int NB = 2*NUM_CH;
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state_q, state_d;
  logic [2:0] ss_q, ss_d, sclk_q, sclk_d;
  logic [1:0] mosi_q, mosi_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d, rx_nxt, resp;
  logic hold_q, hold_d, rw_q, rw_d, ld_rw;
  logic [6:0] addr_q, addr_d, ld_addr, si;
  logic [7:0] mem_q [128];
  logic [16*NUM_CH-1:0] snap_q, snap_d;
  logic [CW-1:0] cnt_q, cnt_d, period;
  logic [3:0] code, code_q;
  logic [2:0] sh;
  logic int_q, int_d, pend_q, pend_d;
  logic ss_s, ss_prev, rise, fall, start, we, clr, en, tc, cap;
  function automatic logic in_data(input logic [6:0] a);
    return int'(a) >= int'(DATA_BASE) && int'(a) < int'(DATA_BASE) + NB;
  endfunction
  assign ss_s = ss_q[1];
  assign ss_prev = ss_q[2];
  assign rise = sclk_q[1] && !sclk_q[2];
  assign fall = !sclk_q[1] && sclk_q[2];
  assign start = ss_prev && !ss_s;
  assign MISO = spi.SS_n ? 1'bz : tx_q[7];
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = ss_s ? IDLE
            : (state_q == IDLE && start) ? CMD
            : (state_q == CMD && rise && bit_cnt_q == 3'd7) ? DATA
            : state_q;
  end
  always_comb begin
    INT = int_q;
    setup = en;
  end
  // Load point serves both the command byte (address just received) and data bytes (next address).
  always_comb begin
    ss_d = {ss_q[1:0], spi.SS_n};
    sclk_d = {sclk_q[1:0], spi.SCLK};
    mosi_d = {mosi_q[0], spi.MOSI};
    rx_nxt = {rx_q[6:0], mosi_q[1]};
    ld_addr = state_q == CMD ? rx_nxt[6:0] : addr_q + 7'd1;
    ld_rw = state_q == CMD ? rx_nxt[7] : rw_q;
    si = in_data(ld_addr) ? ld_addr - DATA_BASE : 7'd0;
    resp = ld_addr == 7'h0F ? WHO_AM_I : in_data(ld_addr) ? snap_q[{si, 3'b000} +: 8] : mem_q[ld_addr];
    bit_cnt_d = bit_cnt_q;
    rx_d = rx_q;
    tx_d = tx_q;
    hold_d = hold_q;
    rw_d = rw_q;
    addr_d = addr_q;
    we = 1'b0;
    clr = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        bit_cnt_d = 3'd0;
        rx_d = 8'd0;
        tx_d = 8'd0;
        hold_d = 1'b0;
      end
    end else if (!ss_s) begin
      if (rise) begin
        rx_d = rx_nxt;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          tx_d = ld_rw ? resp : state_q == CMD ? 8'hA5 : 8'h00;
          hold_d = 1'b1;
          clr = ld_rw && ld_addr == DATA_BASE;
          rw_d = ld_rw;
          addr_d = ld_addr;
          we = state_q == DATA && !rw_q && addr_q != 7'h0F && !in_data(addr_q);
        end
      end else if (fall) begin
        tx_d = hold_q ? tx_q : {tx_q[6:0], 1'b0};
        hold_d = 1'b0;
      end
    end
  end
  // A sample landing mid-burst waits for SS_n high so a burst never mixes samples.
  always_comb begin
    code = mem_q[7'h11][7:4];
    en = mem_q[7'h0D][1] && code != 4'd0;
    sh = code >= 4'd4 ? 3'd0 : 3'd4 - code[2:0];
    period = CW'(ODR_BASE) << sh;
    tc = en && cnt_q == period - CW'(1);
    cnt_d = (!en || code != code_q || tc) ? '0 : cnt_q + CW'(1);
    cap = (tc || pend_q) && ss_s;
    pend_d = (tc || pend_q) && !ss_s;
    snap_d = cap ? sens_data : snap_q;
    int_d = cap ? 1'b1 : clr ? 1'b0 : int_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_q <= '0;
      sclk_q <= '0;
      mosi_q <= '0;
      bit_cnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      hold_q <= 1'b0;
      rw_q <= 1'b0;
      addr_q <= '0;
      snap_q <= '0;
      cnt_q <= '0;
      code_q <= '0;
      int_q <= 1'b0;
      pend_q <= 1'b0;
      for (int i = 0; i < 128; i++) mem_q[i] <= '0;
    end else begin
      ss_q <= ss_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      hold_q <= hold_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      snap_q <= snap_d;
      cnt_q <= cnt_d;
      code_q <= code;
      int_q <= int_d;
      pend_q <= pend_d;
      if (we) mem_q[addr_q] <= rx_nxt;
    end
  end
endmodule

// File: tb/tb_inert_spi_serf.sv
// tb_inert_spi_serf: directed SPI transactions against the serf with hand-computed expectations
module tb_inert_spi_serf;
  localparam int NUM_CH = 6;
  localparam int ODR_BASE = 256;
  localparam int HB = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic miso, int_o, setup;
  logic [16*NUM_CH-1:0] sens, old;
  logic [7:0] wb [16];
  logic [7:0] rb [16];
  logic [7:0] r, d;
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int t1, t2;
  inert_spi_serf_if spi ();
  inert_spi_serf #(.NUM_CH(NUM_CH), .ODR_BASE(ODR_BASE)) dut (
    .clk(clk), .rst(rst), .spi(spi), .MISO(miso), .INT(int_o), .sens_data(sens), .setup(setup)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic wt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ss_lo();
    spi.SS_n = 1'b0;
    wt(5);
  endtask
  task automatic ss_hi();
    wt(5);
    spi.SS_n = 1'b1;
    wt(6);
  endtask
  task automatic xbyte(input logic [7:0] b, input int nbits, output logic [7:0] q);
    q = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi.MOSI = b[i];
      wt(HB);
      q[i] = miso;
      spi.SCLK = 1'b1;
      wt(HB);
      spi.SCLK = 1'b0;
    end
  endtask
  task automatic xfer(input logic [7:0] cmd, input int n);
    logic [7:0] q;
    ss_lo();
    xbyte(cmd, 8, q);
    for (int k = 0; k < n; k++) xbyte(wb[k], 8, rb[k]);
    ss_hi();
  endtask
  task automatic wr(input logic [6:0] a, input logic [7:0] v);
    wb[0] = v;
    xfer({1'b0, a}, 1);
  endtask
  task automatic rd(input logic [6:0] a, output logic [7:0] v);
    wb[0] = 8'h00;
    xfer({1'b1, a}, 1);
    v = rb[0];
  endtask
  task automatic wait_int(input int lim, output int t);
    int k = 0;
    while (!int_o && k < lim) begin
      wt(1);
      k++;
    end
    t = cyc;
    chk("int_rise", int_o, 1);
  endtask
  initial begin
    spi.SS_n = 1'b0;
    spi.SCLK = 1'b0;
    spi.MOSI = 1'b0;
    for (int k = 0; k < 16; k++) wb[k] = 8'h00;
    sens = {16'h6789, 16'h5678, 16'h4567, 16'h3456, 16'h2345, 16'h1234};
    wt(4);
    rst = 1'b0;
    wt(3);
    chk("rst_int", int_o, 0);
    chk("rst_setup", setup, 0);
    chk("rst_miso_low", miso, 0);
    xbyte(8'h0D, 8, r);
    xbyte(8'h02, 8, r);
    spi.SS_n = 1'b1;
    wt(6);
    rd(7'h0D, d);
    chk("no_start_after_rst", d, 8'h00);
    wr(7'h0D, 8'h02);
    chk("wr_resp_a5", rb[0], 8'hA5);
    rd(7'h0D, d);
    chk("rd_0d", d, 8'h02);
    chk("setup_code0", setup, 0);
    rd(7'h0F, d);
    chk("who", d, 8'h6A);
    wr(7'h0F, 8'h55);
    rd(7'h0F, d);
    chk("who_ro", d, 8'h6A);
    wb[0] = 8'h11; wb[1] = 8'h22; wb[2] = 8'h33;
    xfer(8'h7F, 3);
    chk("burst_wr_resp", rb[1], 8'h00);
    rd(7'h7F, d); chk("wrap_7f", d, 8'h11);
    rd(7'h00, d); chk("wrap_00", d, 8'h22);
    rd(7'h01, d); chk("wrap_01", d, 8'h33);
    wb[0] = 8'h00; wb[1] = 8'h00; wb[2] = 8'h00;
    xfer(8'hFF, 3);
    chk("burst_rd_7f", rb[0], 8'h11);
    chk("burst_rd_00", rb[1], 8'h22);
    chk("burst_rd_01", rb[2], 8'h33);
    rd(7'h22, d);
    chk("snap_rst", d, 8'h00);
    wr(7'h11, 8'h40);
    chk("setup_on", setup, 1);
    wait_int(2000, t1);
    rd(7'h22, d);
    chk("snap_ch0_lo", d, 8'h34);
    chk("int_clr", int_o, 0);
    wait_int(2000, t2);
    chk("period_code4", t2 - t1, ODR_BASE);
    ss_lo();
    xbyte(8'hA2, 8, r);
    for (int k = 0; k < 12; k++) xbyte(8'h00, 8, rb[k]);
    chk("burst_int_clr", int_o, 0);
    spi.SS_n = 1'b1;
    wt(6);
    for (int k = 0; k < 12; k++) chk($sformatf("burst_rd_%0d", k), rb[k], sens[8*k +: 8]);
    chk("int_deferred", int_o, 1);
    wr(7'h11, 8'h10);
    rd(7'h22, d);
    chk("int_clr2", int_o, 0);
    wait_int(3000, t1);
    rd(7'h22, d);
    wait_int(3000, t2);
    chk("period_code1", t2 - t1, 8*ODR_BASE);
    old = sens;
    ss_lo();
    xbyte(8'hA2, 8, r);
    xbyte(8'h00, 8, rb[0]);
    xbyte(8'h00, 8, rb[1]);
    sens = {16'hA5A5, 16'h0F0F, 16'hCAFE, 16'hF00D, 16'hD00D, 16'hBEEF};
    wt(2100);
    for (int k = 2; k < 12; k++) xbyte(8'h00, 8, rb[k]);
    chk("coh_int_low", int_o, 0);
    spi.SS_n = 1'b1;
    wt(2);
    chk("coh_int_pre", int_o, 0);
    wt(1);
    chk("coh_int_set", int_o, 1);
    for (int k = 0; k < 12; k++) chk($sformatf("coh_%0d", k), rb[k], old[8*k +: 8]);
    wt(3);
    rd(7'h22, d);
    chk("coh_new", d, 8'hEF);
    wr(7'h05, 8'hAB);
    ss_lo();
    xbyte(8'h05, 8, r);
    xbyte(8'hFF, 5, r);
    spi.SS_n = 1'b1;
    wt(6);
    rd(7'h05, d); chk("abort_keep", d, 8'hAB);
    rd(7'h06, d); chk("abort_no_inc", d, 8'h00);
    ss_lo();
    xbyte(8'h8D, 8, r);
    xbyte(8'h00, 3, r);
    rst = 1'b1;
    wt(3);
    chk("rst_mid_int", int_o, 0);
    chk("rst_mid_setup", setup, 0);
    rst = 1'b0;
    wt(2);
    xbyte(8'h00, 8, r);
    spi.SS_n = 1'b1;
    wt(6);
    rd(7'h11, d); chk("rst_regs", d, 8'h00);
    wr(7'h0D, 8'h02);
    rd(7'h0D, d); chk("post_rst_rw", d, 8'h02);
    rd(7'h22, d); chk("post_rst_snap", d, 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
